// File: rtl/reg_bank.sv
// 32x32 MIPS general-purpose register file. It has two combinational read ports,
// one synchronous write port with optional same-cycle forwarding, and a sequenced
// clear engine that rewrites every register to its reset value without a full reset.
module reg_bank #(
    parameter int unsigned          DATA_W   = 32,
    parameter logic [DATA_W-1:0]    SP_RESET = 227,
    parameter bit                   BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [4:0] SP_IDX   = 5'd29;
    localparam logic [4:0] LAST_IDX = 5'd31;

    logic [0:0]        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [32];
    logic [DATA_W-1:0] mem_d [32];

    logic wr_fire;
    logic last_clr;

    // A write lands only in IDLE and never to $zero. The same qualifier gates the bypass.
    assign wr_fire  = (state_q == IDLE) && wr_en && (wr_addr != 5'd0);
    assign last_clr = (state_q == CLEAR) && (cnt_q == LAST_IDX);

    assign busy     = (state_q == CLEAR);
    assign clr_done = last_clr;

    // Clear sequencer: the sweep covers addresses 1..31 and then returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = 5'd1;
                end
            end
            CLEAR: begin
                if (last_clr) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Array next-state: a normal write in IDLE, or one reset-value write per sweep cycle.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_fire) begin
            mem_d[wr_addr] = wr_data;
        end
        if (state_q == CLEAR) begin
            mem_d[cnt_q] = (cnt_q == SP_IDX) ? SP_RESET : '0;
        end
        // $zero is hardwired; keep its storage pinned so it folds away.
        mem_d[0] = '0;
    end

    // Read port A: zero for $zero, forwarded write data on a same-cycle hit.
    always_comb begin
        rd_data_a = (rd_addr_a == 5'd0) ? '0 : mem_q[rd_addr_a];
        if (BYPASS && wr_fire && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
    end

    // Read port B: same structure as port A.
    always_comb begin
        rd_data_b = (rd_addr_b == 5'd0) ? '0 : mem_q[rd_addr_b];
        if (BYPASS && wr_fire && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
    end

    // State and array flops. An asynchronous reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= (i == 29) ? SP_RESET : '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank. One instance has forwarding enabled and one has it
// disabled. Both instances share every input.
module tb_reg_bank;

    logic        clk;
    logic        reset_n;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [31:0] wr_data;
    logic        wr_en, clr_req;
    logic [31:0] rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b;
    logic        busy, clr_done, nb_busy, nb_clr_done;

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank #(.DATA_W(32), .SP_RESET(32'd227), .BYPASS(1'b1)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .busy      (busy),
        .clr_done  (clr_done)
    );

    reg_bank #(.DATA_W(32), .SP_RESET(32'd227), .BYPASS(1'b0)) u_dut_nb (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (nb_rd_data_a),
        .rd_data_b (nb_rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .busy      (nb_busy),
        .clr_done  (nb_clr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every register on port A of both instances.
    task automatic check_all_reset_values(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = i[4:0];
            #1;
            check($sformatf("%s_r%0d", tag, i), rd_data_a, (i == 29) ? 32'd227 : 32'd0);
            check($sformatf("%s_nb_r%0d", tag, i), nb_rd_data_a, (i == 29) ? 32'd227 : 32'd0);
        end
    endtask

    task automatic start_sweep();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wr_en   = 1'b0;
    endtask

    // Count busy cycles and clr_done pulses until the sweep ends (bounded).
    task automatic measure_sweep(input bit disturb, output int busy_cyc, output int done_at,
                                 output int done_cnt);
        busy_cyc = 0;
        done_at  = -1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) begin
                busy_cyc++;
                if (clr_done) begin
                    done_cnt++;
                    done_at = busy_cyc;
                end
            end
            if (disturb && k == 5) begin
                wr_en   = 1'b1;
                wr_addr = 5'd5;
                wr_data = 32'hFFFF_FFFF;
                clr_req = 1'b1;
            end else if (disturb && k == 6) begin
                wr_en   = 1'b0;
                clr_req = 1'b0;
            end
            tick();
        end
        check("sweep_ended", {31'd0, busy}, 32'd0);
    endtask

    int bc, da, dc;

    initial begin
        reset_n   = 1'b1;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_en     = 1'b0;
        clr_req   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, clr_done}, 32'd0);
        check_all_reset_values("rst");
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Basic write then read on both ports.
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0; rd_addr_a = 5'd8; rd_addr_b = 5'd8;
        #1;
        check("wr8_a", rd_data_a, 32'hDEAD_BEEF);
        check("wr8_b", rd_data_b, 32'hDEAD_BEEF);

        // Writes to $zero are discarded, including through the bypass path.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; rd_addr_a = 5'd0;
        #1;
        check("r0_bypass", rd_data_a, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check("r0_after", rd_data_a, 32'd0);

        // Forwarding in the bypass instance versus the old value in the other instance.
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h0040_0010; rd_addr_a = 5'd31;
        #1;
        check("byp_on", rd_data_a, 32'h0040_0010);
        check("byp_off_old", nb_rd_data_a, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check("byp_on_after", rd_data_a, 32'h0040_0010);
        check("byp_off_after", nb_rd_data_a, 32'h0040_0010);

        // Fill each register with its own index, then run a clean sweep.
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = i[4:0]; wr_data = i;
            tick();
        end
        wr_en = 1'b0;
        rd_addr_a = 5'd29; rd_addr_b = 5'd17;
        #1;
        check("fill_r29", rd_data_a, 32'd29);
        check("fill_r17", rd_data_b, 32'd17);
        start_sweep();
        measure_sweep(1'b0, bc, da, dc);
        check("sweep1_len", bc, 32'd31);
        check("sweep1_done_at", da, 32'd31);
        check("sweep1_done_cnt", dc, 32'd1);
        check_all_reset_values("clr1");

        // Sweep with a write and a second clr_req injected while busy.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd5;
        tick();
        wr_en = 1'b0;
        start_sweep();
        measure_sweep(1'b1, bc, da, dc);
        check("sweep2_len", bc, 32'd31);
        check("sweep2_done_cnt", dc, 32'd1);
        rd_addr_a = 5'd5;
        #1;
        check("sweep2_r5", rd_data_a, 32'd0);

        // Simultaneous clr_req and write: the write lands, then the sweep clears it.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA_5555; rd_addr_a = 5'd3;
        start_sweep();
        check("simul_busy", {31'd0, busy}, 32'd1);
        check("simul_r3", rd_data_a, 32'hAAAA_5555);
        measure_sweep(1'b0, bc, da, dc);
        check("simul_len", bc, 32'd31);
        #1;
        check("simul_r3_clr", rd_data_a, 32'd0);

        // Reset mid-sweep at cnt=10 aborts the sweep and restores $sp.
        wr_en = 1'b1; wr_addr = 5'd29; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        start_sweep();
        for (int k = 0; k < 9; k++) tick();
        rd_addr_a = 5'd29;
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_r29_old", rd_data_a, 32'h55);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, clr_done}, 32'd0);
        check("mid_rst_r29", rd_data_a, 32'd227);
        #1 reset_n = 1'b1;
        tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
